t05_regfile_exec_unit: RTL

//  Parametrised register file plus execute unit with valid/ready handshakes on issue and result.

---
 rtl/t05_regfile_exec_unit.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/t05_regfile_exec_unit.sv
// Register file plus serial execute unit for the team_05 core, with issue/result handshakes.
// Optional macro T05_MUL_EN adds op 16 (MUL) as a 1 bit/cycle shift-add multiplier.
module t05_regfile_exec_unit #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_use_imm,
    input  logic              in_wb,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_rd,
    input  logic [DATA_W-1:0] ext_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_branch,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_err
);

    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = SH_W + 1;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4;
    localparam logic [4:0] OP_SLL  = 5'd5;
    localparam logic [4:0] OP_SRL  = 5'd6;
    localparam logic [4:0] OP_SRA  = 5'd7;
    localparam logic [4:0] OP_SLT  = 5'd8;
    localparam logic [4:0] OP_SLTU = 5'd9;
    localparam logic [4:0] OP_BEQ  = 5'd10;
    localparam logic [4:0] OP_BNE  = 5'd11;
    localparam logic [4:0] OP_BLT  = 5'd12;
    localparam logic [4:0] OP_BGE  = 5'd13;
    localparam logic [4:0] OP_BLTU = 5'd14;
    localparam logic [4:0] OP_BGEU = 5'd15;
`ifdef T05_MUL_EN
    localparam logic [4:0] OP_MUL  = 5'd16;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_HOLD,
        ST_MUL
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               branch_q, branch_d;
    logic               err_q, err_d;
    logic [ADDR_W-1:0]  rd_q, rd_d;
    logic               wb_q, wb_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [1:0]         sop_q, sop_d;
    logic [DATA_W-1:0]  regs_q [NREGS];
    logic [DATA_W-1:0]  regs_d [NREGS];
`ifdef T05_MUL_EN
    logic [DATA_W-1:0]  mcand_q, mcand_d;
    logic [DATA_W-1:0]  mplier_q, mplier_d;
`endif

    logic [DATA_W-1:0]  op_a;
    logic [DATA_W-1:0]  op_b;
    logic               is_shift;
    logic               is_branch;
    logic               is_illegal;

    // Operands are read at accept; a same-cycle load write to a source register is forwarded.
    always_comb begin
        op_a = regs_q[in_rs1];
        if (ext_we && ext_rd == in_rs1) op_a = ext_data;
        if (in_rs1 == '0) op_a = '0;
        op_b = regs_q[in_rs2];
        if (ext_we && ext_rd == in_rs2) op_b = ext_data;
        if (in_rs2 == '0) op_b = '0;
        if (in_use_imm) op_b = in_imm;
    end

    always_comb begin
        is_shift   = (in_op == OP_SLL) || (in_op == OP_SRL) || (in_op == OP_SRA);
        is_branch  = (in_op >= OP_BEQ) && (in_op <= OP_BGEU);
`ifdef T05_MUL_EN
        is_illegal = (in_op > OP_MUL);
`else
        is_illegal = (in_op > OP_BGEU);
`endif
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        branch_d = branch_q;
        err_d    = err_q;
        rd_d     = rd_q;
        wb_d     = wb_q;
        count_d  = count_q;
        sop_d    = sop_q;
        regs_d   = regs_q;
`ifdef T05_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    rd_d     = in_rd;
                    branch_d = 1'b0;
                    err_d    = 1'b0;
                    result_d = '0;
                    count_d  = '0;
                    wb_d     = in_wb && (in_rd != '0) && !is_branch && !is_illegal;
                    state_d  = ST_HOLD;
                    case (in_op)
                        OP_ADD:  result_d = op_a + op_b;
                        OP_SUB:  result_d = op_a - op_b;
                        OP_AND:  result_d = op_a & op_b;
                        OP_OR:   result_d = op_a | op_b;
                        OP_XOR:  result_d = op_a ^ op_b;
                        OP_SLL, OP_SRL, OP_SRA: begin
                            result_d = op_a;
                            sop_d    = in_op[1:0];
                            count_d  = CNT_W'(op_b[SH_W-1:0]);
                            if (op_b[SH_W-1:0] != '0) state_d = ST_SHIFT;
                        end
                        OP_SLT:  result_d[0] = $signed(op_a) < $signed(op_b);
                        OP_SLTU: result_d[0] = op_a < op_b;
                        OP_BEQ:  branch_d = (op_a == op_b);
                        OP_BNE:  branch_d = (op_a != op_b);
                        OP_BLT:  branch_d = $signed(op_a) < $signed(op_b);
                        OP_BGE:  branch_d = $signed(op_a) >= $signed(op_b);
                        OP_BLTU: branch_d = op_a < op_b;
                        OP_BGEU: branch_d = op_a >= op_b;
`ifdef T05_MUL_EN
                        OP_MUL: begin
                            mcand_d  = op_a;
                            mplier_d = op_b;
                            count_d  = CNT_W'(DATA_W);
                            state_d  = ST_MUL;
                        end
`endif
                        default: err_d = 1'b1;
                    endcase
                end
            end
            // sop_q holds op[1:0]: 01 SLL, 10 SRL, 11 SRA
            ST_SHIFT: begin
                case (sop_q)
                    2'b01:   result_d = {result_q[DATA_W-2:0], 1'b0};
                    2'b10:   result_d = {1'b0, result_q[DATA_W-1:1]};
                    default: result_d = {result_q[DATA_W-1], result_q[DATA_W-1:1]};
                endcase
                count_d = count_q - 1'b1;
                if (count_q == CNT_W'(1)) state_d = ST_HOLD;
            end
`ifdef T05_MUL_EN
            ST_MUL: begin
                if (mplier_q[0]) result_d = result_q + mcand_q;
                mcand_d  = {mcand_q[DATA_W-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[DATA_W-1:1]};
                count_d  = count_q - 1'b1;
                if (count_q == CNT_W'(1)) state_d = ST_HOLD;
            end
`endif
            ST_HOLD: begin
                if (out_ready) begin
                    if (wb_q) regs_d[rd_q] = result_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Load data is applied last so it wins over a same-cycle result writeback.
        if (ext_we) regs_d[ext_rd] = ext_data;
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            branch_q <= 1'b0;
            err_q    <= 1'b0;
            rd_q     <= '0;
            wb_q     <= 1'b0;
            count_q  <= '0;
            sop_q    <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
`ifdef T05_MUL_EN
            mcand_q  <= '0;
            mplier_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            branch_q <= branch_d;
            err_q    <= err_d;
            rd_q     <= rd_d;
            wb_q     <= wb_d;
            count_q  <= count_d;
            sop_q    <= sop_d;
            regs_q   <= regs_d;
`ifdef T05_MUL_EN
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
`endif
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_HOLD);
    assign out_result = result_q;
    assign out_branch = branch_q;
    assign out_rd     = rd_q;
    assign out_err    = err_q;

endmodule
